ipf_conv_engine: RTL

Parametrised successor to the fixed-function image filter. It accepts a runtime-selected square kernel of 3×3, 5×5 or 7×7 and loads its weights over a valid/ready port. It buffers a sliding window of input rows and produces one fully accumulated output row of LANES pixels per window position, over a valid/ready output port. It sits between the image row fetcher and the post-processing/writeback stage.

---
 rtl/ipf_pkg.sv | 35 +++
 rtl/ipf_row_mac.sv | 47 ++++
 rtl/ipf_conv_engine.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ipf_pkg.sv
// Shared types and sizing helpers for the ipf convolution engine.
package ipf_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOADW   = 3'd1,
      FILL    = 3'd2,
      COMPUTE = 3'd3,
      OUT     = 3'd4
   } ipf_state_e;

   localparam logic [1:0] WSIZE_3X3  = 2'd0;
   localparam logic [1:0] WSIZE_5X5  = 2'd1;
   localparam logic [1:0] WSIZE_7X7  = 2'd2;
   localparam logic [1:0] WSIZE_RSVD = 2'd3;

   // 2*DW product bits plus 6 bits of growth covers 49 taps at MAXK=7
   function automatic int accw(input int dw);
      return 2 * dw + 6;
   endfunction

   function automatic int ksize(input logic [1:0] wsize);
      case (wsize)
         WSIZE_3X3: return 3;
         WSIZE_5X5: return 5;
         WSIZE_7X7: return 7;
         default:   return 0;
      endcase
   endfunction

   function automatic int wbeats(input int k, input int dw, input int wbus);
      return (k * k * dw + wbus - 1) / wbus;
   endfunction

endpackage

// File: rtl/ipf_row_mac.sv
// Combinational multiply-accumulate of one buffered row against one kernel row, with zero padding.
// IPF_SIGNED_WEIGHT_EN selects sign-extended (two's-complement) weights; pixels are always unsigned.
module ipf_row_mac
   import ipf_pkg::*;
#(
   parameter int DW    = 8,
   parameter int LANES = 8,
   parameter int MAXK  = 7,
   parameter int ACCW  = accw(DW),
   parameter int KW    = $clog2(MAXK + 1)
) (
   input  logic [LANES*DW-1:0]   row,
   input  logic [MAXK*DW-1:0]    wrow,
   input  logic [KW-1:0]         k,
   output logic [LANES*ACCW-1:0] psum
);

   function automatic logic [ACCW-1:0] wext(input logic [DW-1:0] w);
`ifdef IPF_SIGNED_WEIGHT_EN
      return {{(ACCW-DW){w[DW-1]}}, w};
`else
      return {{(ACCW-DW){1'b0}}, w};
`endif
   endfunction

   int              half;
   int              src;
   logic [ACCW-1:0] sum;

   // Truncated ACCW-bit products are identical for signed and unsigned once operands are extended
   always_comb begin
      psum = '0;
      half = (int'(k) - 1) / 2;
      src  = 0;
      sum  = '0;
      for (int j = 0; j < LANES; j++) begin
         sum = '0;
         for (int c = 0; c < MAXK; c++) begin
            src = j + c - half;
            if (c < int'(k) && src >= 0 && src < LANES)
               sum = sum + wext(wrow[c*DW +: DW]) * {{(ACCW-DW){1'b0}}, row[src*DW +: DW]};
         end
         psum[j*ACCW +: ACCW] = sum;
      end
   end

endmodule

// File: rtl/ipf_conv_engine.sv
// Runtime 3x3/5x5/7x7 row convolution: weight load, sliding row window, K-cycle accumulate; K+1 cycle latency.
// o_valid holds until o_ready; i_ready only in FILL; IPF_SIGNED_WEIGHT_EN enables signed weights.
module ipf_conv_engine
   import ipf_pkg::*;
#(
   parameter int DW    = 8,
   parameter int LANES = 8,
   parameter int MAXK  = 7,
   parameter int WBUS  = 64,
   parameter int ACCW  = accw(DW)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_start,
   input  logic [1:0]            cfg_wsize,
   input  logic                  cfg_clear,
   input  logic                  w_valid,
   output logic                  w_ready,
   input  logic [WBUS-1:0]       w_data,
   input  logic                  i_valid,
   output logic                  i_ready,
   input  logic [LANES*DW-1:0]   i_data,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic [LANES*ACCW-1:0] o_data,
   output logic                  busy,
   output logic                  err
);

   localparam int KW  = $clog2(MAXK + 1);
   localparam int WPB = WBUS / DW;
   localparam int NW  = MAXK * MAXK;
   localparam int NWW = $clog2(NW);
   localparam int BW  = $clog2(wbeats(MAXK, DW, WBUS) + 1);

   ipf_state_e state, state_nxt;

   logic [KW-1:0]         k_q;
   logic [KW-1:0]         held_q;
   logic [KW-1:0]         cyc_q;
   logic [BW-1:0]         beat_q;
   logic [DW-1:0]         w_mem [NW];
   logic [LANES*DW-1:0]   rows  [MAXK];
   logic [MAXK*DW-1:0]    wrow;
   logic [LANES*ACCW-1:0] psum;
   logic [LANES*ACCW-1:0] acc_q;

   logic start_ok, w_fire, i_fire, o_fire, w_last, win_full, cmp_last;

   assign start_ok = (state == IDLE) && cfg_start && (cfg_wsize != WSIZE_RSVD);
   assign w_fire   = w_valid && w_ready;
   assign i_fire   = i_valid && i_ready;
   assign o_fire   = o_valid && o_ready;
   assign w_last   = (beat_q == BW'(wbeats(int'(k_q), DW, WBUS) - 1));
   assign win_full = (held_q >= k_q - KW'(1));
   assign cmp_last = (cyc_q == k_q - KW'(1));
   assign o_data   = acc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_ok)          state_nxt = LOADW;
         LOADW:   if (w_fire && w_last)  state_nxt = FILL;
         FILL:    if (i_fire && win_full) state_nxt = COMPUTE;
         COMPUTE: if (cmp_last)          state_nxt = OUT;
         OUT:     if (o_fire)            state_nxt = FILL;
         default:                        state_nxt = IDLE;
      endcase
      if (cfg_clear) state_nxt = IDLE;
   end

   always_comb begin
      w_ready = (state == LOADW) && !cfg_clear;
      i_ready = (state == FILL) && !cfg_clear;
      o_valid = (state == OUT);
      busy    = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_q    <= KW'(3);
         held_q <= '0;
         cyc_q  <= '0;
         beat_q <= '0;
         err    <= 1'b0;
         acc_q  <= '0;
      end else begin
         err <= (state == IDLE) && cfg_start && (cfg_wsize == WSIZE_RSVD) && !cfg_clear;
         if (start_ok && !cfg_clear) k_q <= KW'(ksize(cfg_wsize));

         if (state != LOADW) beat_q <= '0;
         else if (w_fire)    beat_q <= beat_q + BW'(1);

         // rows_held saturates at K so a full window re-arms on every new row
         if (cfg_clear || state == IDLE || state == LOADW) held_q <= '0;
         else if (i_fire && held_q != k_q)                 held_q <= held_q + KW'(1);

         if (state != COMPUTE) cyc_q <= '0;
         else                  cyc_q <= cyc_q + KW'(1);

         if (state == COMPUTE)
            for (int j = 0; j < LANES; j++)
               acc_q[j*ACCW +: ACCW] <= ((cyc_q == '0) ? {ACCW{1'b0}} : acc_q[j*ACCW +: ACCW])
                                        + psum[j*ACCW +: ACCW];
      end
   end

   // Weight store and row window survive cfg_clear; a new job always reloads weights
   always_ff @(posedge clk) begin
      if (w_fire)
         for (int b = 0; b < WPB; b++)
            if (int'(beat_q) * WPB + b < NW)
               w_mem[NWW'(int'(beat_q) * WPB + b)] <= w_data[b*DW +: DW];
      if (i_fire) begin
         for (int i = 0; i < MAXK - 1; i++)
            if (i < int'(k_q) - 1) rows[i] <= rows[i+1];
         rows[k_q - KW'(1)] <= i_data;
      end
   end

   always_comb begin
      wrow = '0;
      for (int c = 0; c < MAXK; c++)
         if (int'(cyc_q) * int'(k_q) + c < NW)
            wrow[c*DW +: DW] = w_mem[NWW'(int'(cyc_q) * int'(k_q) + c)];
   end

   ipf_row_mac #(
      .DW    (DW),
      .LANES (LANES),
      .MAXK  (MAXK),
      .ACCW  (ACCW),
      .KW    (KW)
   ) u_row_mac (
      .row   (rows[cyc_q]),
      .wrow  (wrow),
      .k     (k_q),
      .psum  (psum)
   );

endmodule
